// File: rtl/div32.sv
// div32: sequential 32-bit non-restoring divider, one quotient bit per cycle.
// Define DIV32_SIGNED_EN to build the signed (two's complement) path.
module div32 (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        ready
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      r_state, w_next;
  logic [32:0] r_pr, w_sh, w_res;
  logic [31:0] r_dd, r_dv, w_ua, w_ub, w_rem, w_qf, w_rf;
  logic [4:0]  r_cnt;
  logic        w_load;
  assign w_load = r_state == IDLE && start;
  assign w_sh   = {r_pr[31:0], r_dd[31]};
  assign w_res  = r_pr[32] ? w_sh + {1'b0, r_dv} : w_sh - {1'b0, r_dv};
  assign w_rem  = r_pr[32] ? r_pr[31:0] + r_dv : r_pr[31:0];
`ifdef DIV32_SIGNED_EN
  logic r_qs, r_rs;
  assign w_ua = (sign & a[31]) ? -a : a;
  assign w_ub = (sign & b[31]) ? -b : b;
  assign w_qf = r_qs ? -r_dd : r_dd;
  assign w_rf = r_rs ? -w_rem : w_rem;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_qs <= 1'b0;
      r_rs <= 1'b0;
    end else if (w_load) begin
      r_qs <= sign & (a[31] ^ b[31]);
      r_rs <= sign & a[31];
    end
`else
  logic w_unused;
  assign w_unused = sign;
  assign w_ua = a;
  assign w_ub = b;
  assign w_qf = r_dd;
  assign w_rf = w_rem;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = &r_cnt ? FIX : RUN;
      default: w_next = IDLE;
    endcase
  end
  // Zero divisor leaves the dividend in the remainder naturally; only q is forced.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_state <= IDLE;
      r_pr    <= '0;
      r_dd    <= '0;
      r_dv    <= '0;
      r_cnt   <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= w_next != IDLE;
      ready   <= r_state == FIX;
      if (w_load) begin
        r_pr  <= '0;
        r_dd  <= w_ua;
        r_dv  <= w_ub;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_pr  <= w_res;
        r_dd  <= {r_dd[30:0], ~w_res[32]};
        r_cnt <= r_cnt + 5'd1;
      end else if (r_state == FIX) begin
        q <= r_dv == '0 ? '1 : w_qf;
        r <= w_rf;
      end
    end
endmodule

// File: tb/tb_div32.sv
// tb_div32: vector table, handshake/reset sequences and random checks of div32.
module tb_div32;
`ifdef DIV32_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  logic clk = 0, clrn = 1, start = 0, sign = 0;
  logic [31:0] a = 0, b = 0, q, r;
  logic busy, ready;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] eq, er;
  } vec_t;
  vec_t vecs[10];

  div32 dut (.clk(clk), .clrn(clrn), .start(start), .sign(sign), .a(a), .b(b),
             .q(q), .r(r), .busy(busy), .ready(ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] x, input logic [31:0] y, input bit s,
                       output logic [31:0] mq, output logic [31:0] mr);
    if (y == 0) begin
      mq = '1;
      mr = x;
    end else if (SEN && s) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        mq = 32'h80000000;
        mr = 0;
      end else begin
        mq = $signed(x) / $signed(y);
        mr = $signed(x) % $signed(y);
      end
    end else begin
      mq = x / y;
      mr = x % y;
    end
  endtask

  task automatic wait_ready(input int e0, output int lat, output int bc);
    bc = 0;
    while (!ready && cyc - e0 < 40) begin
      bc += int'(busy);
      @(posedge clk); #1;
    end
    lat = cyc - e0;
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input bit ts,
                       output int lat, output int bc);
    int e0;
    @(negedge clk);
    a = ta; b = tbv; sign = ts; start = 1;
    @(posedge clk); #1;
    start = 0;
    e0 = cyc;
    wait_ready(e0, lat, bc);
  endtask

  initial begin
    int lat, bc, e0, nr;
    logic [31:0] mq, mr, ra, rb;
    bit rs;
    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2};
    vecs[1] = '{32'hFFFFFF9C, 32'd7, 1'b1, SEN ? 32'hFFFFFFF2 : 32'h24924916, SEN ? 32'hFFFFFFFE : 32'd2};
    vecs[2] = '{32'd100, 32'hFFFFFFF9, 1'b1, SEN ? 32'hFFFFFFF2 : 32'd0, SEN ? 32'd2 : 32'd100};
    vecs[3] = '{32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678};
    vecs[4] = '{32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678};
    vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, SEN ? 32'h80000000 : 32'd0, SEN ? 32'd0 : 32'h80000000};
    vecs[6] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0};
    vecs[7] = '{32'd9, 32'd3, 1'b0, 32'd3, 32'd0};
    vecs[8] = '{32'h87654321, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h87654321};
    vecs[9] = '{32'd5, 32'd10, 1'b0, 32'd0, 32'd5};

    #3 clrn = 0;
    #2;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) clrn = 1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, bc);
      chk($sformatf("vec%0d_lat", i), lat, 33);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 33);
      chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
      chk($sformatf("vec%0d_r", i), r, vecs[i].er);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ready_fall", i), {31'd0, ready}, 0);
    end

    @(negedge clk);
    a = 1000; b = 7; sign = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    e0 = cyc;
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 5; b = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_ready(e0, lat, bc);
    chk("ign_lat", lat, 33);
    chk("ign_q", q, 142);
    chk("ign_r", r, 6);

    @(negedge clk);
    a = 100; b = 7; sign = 0; start = 1;
    @(posedge clk); #1;
    e0 = cyc;
    a = 9; b = 3;
    wait_ready(e0, lat, bc);
    chk("b2b_lat1", lat, 33);
    chk("b2b_q1", q, 14);
    chk("b2b_r1", r, 2);
    @(posedge clk); #1;
    chk("b2b_busy", {31'd0, busy}, 1);
    chk("b2b_ready_low", {31'd0, ready}, 0);
    start = 0;
    e0 = cyc;
    wait_ready(e0, lat, bc);
    chk("b2b_lat2", lat, 33);
    chk("b2b_q2", q, 3);
    chk("b2b_r2", r, 0);

    do_op(32'd77, 32'd5, 1'b0, lat, bc);
    @(negedge clk);
    a = 100; b = 7; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (15) @(posedge clk);
    #2 clrn = 0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, ready}, 0);
    @(negedge clk) clrn = 1;
    nr = 0;
    repeat (40) begin
      @(posedge clk); #1;
      nr += int'(ready);
    end
    chk("abort_no_ready", nr, 0);
    do_op(32'd9, 32'd3, 1'b0, lat, bc);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_q", q, 3);
    chk("post_rst_r", r, 0);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(1, 300);
        1: rb = -$urandom_range(1, 300);
        2: rb = $urandom_range(0, 1);
        default: rb = $urandom();
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, mq, mr);
      do_op(ra, rb, rs, lat, bc);
      chk($sformatf("rnd%0d_lat", k), lat, 33);
      chk($sformatf("rnd%0d_q a=%h b=%h s=%0d", k, ra, rb, rs), q, mq);
      chk($sformatf("rnd%0d_r a=%h b=%h s=%0d", k, ra, rb, rs), r, mr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div32.md
# div32

Sequential 32-bit non-restoring divider for the CPU execute stage, the inverse-operation counterpart of the combinational 32-bit adder/subtractor. Each iteration performs one conditional add or subtract of the divisor against a running partial remainder, one quotient bit per cycle. A start/busy/ready handshake with the pipeline control unit lets the pipeline stall on `busy` and latch `q`/`r` on `ready`.

## Interface
Parameters: none (width fixed at 32).

Ports:
- `clk`  in  1  rising-edge clock
- `clrn`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled on rising edge while `busy`=0
- `sign`  in  1  1 = signed (two's complement) division, 0 = unsigned; sampled with `start`
- `a`  in  32  dividend; sampled with `start`
- `b`  in  32  divisor; sampled with `start`
- `q`  out  32  quotient, registered
- `r`  out  32  remainder, registered
- `busy`  out  1  division in progress
- `ready`  out  1  one-cycle pulse: `q`/`r` updated this cycle

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; 5-bit iteration counter counts 0..31.
  - FIX: `busy`=1; remainder correction and sign fix-up.
- Transitions:
  - IDLE -> RUN on `start`=1.
  - RUN -> FIX after 32 iterations.
  - FIX -> IDLE unconditionally.
- Load, on the `start` edge:
  - Register magnitudes |a| and |b| when signed, raw values when unsigned.
  - Record the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
  - Clear the partial remainder (33 bits) and the counter.
- RUN iteration:
  - Shift {partial remainder, dividend} left by 1.
  - If the partial remainder is ≥ 0, subtract the divisor; otherwise add it.
  - The new quotient bit is the inverted sign of the result.
  - All arithmetic is 33-bit so the carry is retained.
- FIX:
  - If the final partial remainder is negative, add the divisor once.
  - Signed mode: negate q if the quotient sign is 1, and negate r if the remainder sign is 1. Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Write `q`/`r` and assert `ready`.
- Divide by zero (b=0): no special path; the normal iteration runs and the result is forced in FIX to `q`=0xFFFFFFFF and `r`=a, in both modes.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): `q`=0x80000000, `r`=0.
- `start` while `busy`=1: ignored. The in-flight operation and its operands are unaffected.
- `q`/`r` hold the last result until the next FIX. They never show intermediate values.

## Timing
- Reset (`clrn`=0, asynchronous, any state including mid-RUN):
  - State returns to IDLE and the operation is aborted with no `ready`.
  - `q`=0, `r`=0, `busy`=0, `ready`=0; internal registers cleared.
- Let edge E0 be the edge that samples `start`=1 in IDLE.
  - `busy` rises after E0.
  - Iterations happen on E1..E32.
  - FIX happens on E33, after which `busy`=0, `ready`=1, and `q`/`r` are valid.
  - `ready` falls after E34.
- Latency from the start edge to result valid is 33 cycles.
- Throughput is one division per 34 cycles. A new `start` asserted during the `ready` cycle is accepted at E34, so back-to-back operations are possible.
- `busy` is registered and glitch-free, so it can drive the pipeline stall directly.

## Configuration
- `DIV32_SIGNED_EN` defined:
  - Signed path is present: operand absolute values and result negation are built, and `sign` is honoured.
- `DIV32_SIGNED_EN` undefined:
  - The `sign` port remains but is ignored; all divisions are unsigned and no negation logic is built.
  - The signed-overflow case is not applicable: a=0x80000000, b=0xFFFFFFFF gives `q`=0, `r`=0x80000000.
  - Divide-by-zero behaviour is unchanged.

## Test plan
- Unsigned: a=100, b=7, `sign`=0, pulse `start` -> exactly 33 cycles later `ready`=1 for one cycle, `q`=14, `r`=2; `busy` high for 33 cycles.
- Signed (macro defined): a=-100 (0xFFFFFF9C), b=7 -> `q`=0xFFFFFFF2 (-14), `r`=0xFFFFFFFE (-2); then a=100, b=-7 -> `q`=-14, `r`=2.
- Corner cases:
  - Divide by zero: a=0x12345678, b=0 (both modes) -> `q`=0xFFFFFFFF, `r`=0x12345678.
  - Signed overflow: a=0x80000000, b=0xFFFFFFFF, `sign`=1 -> `q`=0x80000000, `r`=0.
  - Unsigned a=0xFFFFFFFF, b=1 -> `q`=0xFFFFFFFF, `r`=0.
- Handshake:
  - Pulse `start` again at cycle 10 of an operation with different operands -> ignored; the original result appears at cycle 33.
  - `start` held high through the `ready` cycle -> second operation begins at E34.
- Reset mid-operation: assert `clrn`=0 at iteration 15 -> `busy`, `ready`, `q`, `r` go to 0 immediately; no `ready` follows; the next `start` (a=9, b=3) yields `q`=3, `r`=0.
